// File: rtl/relay_alu_sequencer_pkg.sv
// rtl/relay_alu_sequencer_pkg.sv - shared types and default relay timing for the ALU sequencer
package relay_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_INC = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_CLR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_RELEASE,
    ST_DONE
  } seq_state_e;

  typedef enum logic {
    DST_A = 1'b0,
    DST_D = 1'b1
  } dst_e;

  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_LOAD_CYCLES    = 2;
  localparam int DEF_RELEASE_CYCLES = 3;
  localparam int DEF_CNT_W          = 4;

endpackage

// File: rtl/relay_alu_sequencer_if.sv
// rtl/relay_alu_sequencer_if.sv - decoder request and relay control signals of the ALU sequencer
interface relay_alu_sequencer_if;
  import relay_pkg::*;

  logic    start;
  alu_op_e op;
  dst_e    dst;
  logic    busy;
  logic    done;
  logic    sel_b;
  logic    sel_c;
  alu_op_e alu_fn;
  logic    ld_a;
  logic    ld_d;
  logic    ld_cond;

  modport master (
    output start, op, dst,
    input  busy, done, sel_b, sel_c, alu_fn, ld_a, ld_d, ld_cond
  );

  modport slave (
    input  start, op, dst,
    output busy, done, sel_b, sel_c, alu_fn, ld_a, ld_d, ld_cond
  );
endinterface

// File: rtl/relay_alu_sequencer_timer.sv
// rtl/relay_alu_sequencer_timer.sv - loadable down-counter timing each relay phase
module relay_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Holds at zero when not reloaded, so an idle sequencer never wraps.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/relay_alu_sequencer.sv
// rtl/relay_alu_sequencer.sv - sequences select, load and release phases of one relay ALU operation
module relay_alu_sequencer
  import relay_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int LOAD_CYCLES    = DEF_LOAD_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  relay_alu_sequencer_if.slave  io_bus
);

  seq_state_e       r_state, w_state_nxt;
  alu_op_e          r_op, w_op_nxt;
  dst_e             r_dst, w_dst_nxt;
  logic             r_busy, r_done, r_sel, r_ld_a, r_ld_d, r_ld_cond;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_zero;

  relay_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .o_zero    (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_dst_nxt   = r_dst;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          w_state_nxt = ST_SETTLE;
          w_op_nxt    = io_bus.op;
          w_dst_nxt   = io_bus.dst;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_LOAD;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CNT_W'(LOAD_CYCLES - 1);
        end
      end
      ST_LOAD: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_RELEASE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CNT_W'(RELEASE_CYCLES - 1);
        end
      end
      ST_RELEASE: begin
        if (w_tmr_zero) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_op_nxt    = OP_ADD;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_op_nxt    = OP_ADD;
      end
    endcase
  end

  // Outputs are flopped from the next-state decode so they switch in step with the state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_ADD;
      r_dst     <= DST_A;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sel     <= 1'b0;
      r_ld_a    <= 1'b0;
      r_ld_d    <= 1'b0;
      r_ld_cond <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_dst     <= w_dst_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      r_sel     <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_LOAD);
      r_ld_a    <= (w_state_nxt == ST_LOAD) && (w_dst_nxt == DST_A);
      r_ld_d    <= (w_state_nxt == ST_LOAD) && (w_dst_nxt == DST_D);
      r_ld_cond <= (w_state_nxt == ST_LOAD);
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.sel_b   = r_sel;
  assign io_bus.sel_c   = r_sel;
  assign io_bus.alu_fn  = r_op;
  assign io_bus.ld_a    = r_ld_a;
  assign io_bus.ld_d    = r_ld_d;
  assign io_bus.ld_cond = r_ld_cond;

endmodule

// File: tb/tb_relay_alu_sequencer.sv
// tb/tb_relay_alu_sequencer.sv - directed self-checking bench for the relay ALU sequencer
module tb_relay_alu_sequencer;
  import relay_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  relay_alu_sequencer_if bus ();
  relay_alu_sequencer_if bus1 ();

  relay_alu_sequencer #(
    .SETTLE_CYCLES(4), .LOAD_CYCLES(2), .RELEASE_CYCLES(3), .CNT_W(4)
  ) dut (
    .i_clock(clk), .i_reset(rst), .io_bus(bus)
  );

  relay_alu_sequencer #(
    .SETTLE_CYCLES(1), .LOAD_CYCLES(1), .RELEASE_CYCLES(1), .CNT_W(4)
  ) dut_min (
    .i_clock(clk), .i_reset(rst), .io_bus(bus1)
  );

  logic [6:0] w_obs, w_obs1;
  assign w_obs  = {bus.busy, bus.done, bus.sel_b, bus.sel_c, bus.ld_a, bus.ld_d, bus.ld_cond};
  assign w_obs1 = {bus1.busy, bus1.done, bus1.sel_b, bus1.sel_c, bus1.ld_a, bus1.ld_d, bus1.ld_cond};

  // Expected {busy,done,sel_b,sel_c,ld_a,ld_d,ld_cond} in cycle m after the accepting edge.
  function automatic logic [6:0] exp_vec(int m, int s, int l, int r, dst_e d);
    logic b, dn, sl, ld;
    b  = (m >= 1) && (m <= s + l + r + 1);
    dn = (m == s + l + r + 1);
    sl = (m >= 1) && (m <= s + l);
    ld = (m > s) && (m <= s + l);
    return {b, dn, sl, sl, ld && (d == DST_A), ld && (d == DST_D), ld};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (w_obs !== 7'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: got %b expected %b", k, w_obs, 7'b0);
      end
      checks++;
      if (bus.alu_fn !== OP_ADD) begin
        failures++;
        $display("FAIL reset_alu_fn cycle %0d: got %0d expected 0", k, bus.alu_fn);
      end
    end
    checks++;
    if (w_obs1 !== 7'b0) begin
      failures++;
      $display("FAIL reset_idle_min: got %b expected %b", w_obs1, 7'b0);
    end
  endtask

  task automatic test_and_dst_a();
    logic [6:0] e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_AND; bus.dst = DST_A;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_vec(k, 4, 2, 3, DST_A);
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL and_dst_a cycle %0d: got %b expected %b", k, w_obs, e);
      end
      if (k <= 9 || k >= 11) begin
        checks++;
        if (bus.alu_fn !== ((k <= 9) ? OP_AND : OP_ADD)) begin
          failures++;
          $display("FAIL and_alu_fn cycle %0d: got %0d expected %0d", k, bus.alu_fn,
                   (k <= 9) ? 2 : 0);
        end
      end
    end
  endtask

  task automatic test_latched_inputs();
    logic [6:0] e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_ADD; bus.dst = DST_D;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 3) begin
        bus.op = OP_CLR; bus.dst = DST_A;
      end
      e = exp_vec(k, 4, 2, 3, DST_D);
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL latch_dst_d cycle %0d: got %b expected %b", k, w_obs, e);
      end
      checks++;
      if (bus.alu_fn !== OP_ADD) begin
        failures++;
        $display("FAIL latch_alu_fn cycle %0d: got %0d expected 0", k, bus.alu_fn);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    int m;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_OR; bus.dst = DST_D;
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      m = (k > 11) ? k - 11 : k;
      if (k == 23) m = 12;
      e = exp_vec(m, 4, 2, 3, DST_D);
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k, w_obs, e);
      end
      if (k == 11 || k == 12) begin
        checks++;
        if (bus.alu_fn !== ((k == 12) ? OP_OR : OP_ADD)) begin
          failures++;
          $display("FAIL b2b_alu_fn cycle %0d: got %0d expected %0d", k, bus.alu_fn,
                   (k == 12) ? 3 : 0);
        end
      end
      if (k == 22) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_load();
    logic [6:0] e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_XOR; bus.dst = DST_A;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = (k <= 5) ? exp_vec(k, 4, 2, 3, DST_A) : 7'b0;
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", k, w_obs, e);
      end
      if (k == 6) begin
        checks++;
        if (bus.alu_fn !== OP_ADD) begin
          failures++;
          $display("FAIL reset_mid_alu_fn: got %0d expected 0", bus.alu_fn);
        end
      end
      rst = (k == 5);
    end
    bus.start = 1'b1; bus.op = OP_NOT; bus.dst = DST_D;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = exp_vec(k, 4, 2, 3, DST_D);
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL after_reset cycle %0d: got %b expected %b", k, w_obs, e);
      end
      if (k <= 9) begin
        checks++;
        if (bus.alu_fn !== OP_NOT) begin
          failures++;
          $display("FAIL after_reset_alu_fn cycle %0d: got %0d expected 5", k, bus.alu_fn);
        end
      end
    end
  endtask

  task automatic test_min_timing();
    logic [6:0] e;
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = OP_SHL; bus1.dst = DST_A;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      e = exp_vec(k, 1, 1, 1, DST_A);
      checks++;
      if (w_obs1 !== e) begin
        failures++;
        $display("FAIL min_timing cycle %0d: got %b expected %b", k, w_obs1, e);
      end
      if (k <= 3) begin
        checks++;
        if (bus1.alu_fn !== OP_SHL) begin
          failures++;
          $display("FAIL min_alu_fn cycle %0d: got %0d expected 6", k, bus1.alu_fn);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;  bus.op = OP_ADD;  bus.dst = DST_A;
    bus1.start = 1'b0; bus1.op = OP_ADD; bus1.dst = DST_A;
    test_reset();
    test_and_dst_a();
    test_latched_inputs();
    test_back_to_back();
    test_reset_mid_load();
    test_min_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
